trivium_prng: RTL and testbench
===============================

# trivium_prng

Trivium keystream generator that feeds 128-bit random words to the binomial sampler over the `rdi_data`/`rdi_valid`/`rdi_ready` interface. It accepts a 256-bit seed on a `reseed` pulse, runs the Trivium warm-up, acknowledges with `reseed_ack`, and then serves one fresh word per consumer request. It is the producer end of the sampler's PRNG link and sits between the seed RAM path and the sampler in the key-generation datapath.

## Interface
- `UNROLL`, default 32: Trivium rounds per clock; legal values are 1, 2, 4, 8, 16, 32, 64.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `seed`  in  256  seed; sampled only in a cycle with `reseed`=1.
- `reseed`  in  1  single-cycle pulse; start key/IV load and warm-up.
- `reseed_ack`  out  1  single-cycle pulse; warm-up complete.
- `rdi_data`  out  128  keystream word; first keystream bit is bit 0.
- `rdi_valid`  out  1  `rdi_data` holds a fresh, unconsumed word.
- `rdi_ready`  in  1  single-cycle request pulse from the consumer for the next word.

## Operation
- Internal state is `st[287:0]`, with `st[k-1]` = Trivium s_k.
- Load on `reseed`:
  - `st[79:0]` = `seed[79:0]` (key).
  - `st[172:93]` = `seed[159:80]` (IV).
  - `st[287:285]` = 3'b111.
  - All other state bits are 0. `seed[255:160]` is ignored.
- Round:
  - t1 = s66^s93, t2 = s162^s177, t3 = s243^s288.
  - z = t1^t2^t3.
  - t1 ^= s91&s92^s171; t2 ^= s175&s176^s264; t3 ^= s286&s287^s69.
  - Shift registers A/B/C by one; new s1 = t3, s94 = t1, s178 = t2.
- States:
  - **UNSEEDED**: after `rst`. Requests set `pend`. `reseed` → WARMUP.
  - **WARMUP**: runs 1152/`UNROLL` cycles with z discarded, then pulses `reseed_ack` and goes to GEN.
  - **GEN**: collects 128/`UNROLL` cycles of z into the shift buffer, LSB first. On completion the buffer is full; the block then serves `pend` or goes to IDLE.
  - **IDLE**: generator halted with the buffer full or empty per configuration. A request → GEN or serve.
- Request handling:
  - A cycle with `rdi_ready`=1 sets `pend` and forces `rdi_valid`=0 in the next cycle.
  - `pend` is served when a full word exists: `rdi_data` ← word, `rdi_valid` ← 1, `pend` ← 0.
  - `rdi_data` changes only in the serve cycle and is otherwise held stable. The consumer may parse it over arbitrarily many cycles.
  - Requests arriving while `pend`=1 are merged; at most one request is outstanding.
- `reseed` at any time (GEN, IDLE, or mid-WARMUP):
  - Reloads state and restarts warm-up.
  - Discards the buffer; `rdi_valid` ← 0.
  - Keeps `pend`, which is served with the first word from the new seed.
- If `reseed` and `rdi_ready` occur in the same cycle, both take effect.
- `rst` in any state → UNSEEDED and clears all registers.

## Timing
- Reset values:
  - `rdi_valid`=0, `reseed_ack`=0, `rdi_data`=0, `st`=0, `pend`=0.
- `reseed` sampled at cycle t, with `UNROLL`=32:
  - Warm-up occupies cycles t+1..t+36.
  - `reseed_ack`=1 at cycle t+37 only.
  - General case: `reseed_ack` at t+1+1152/`UNROLL`.
- Request at t, buffer empty:
  - Generation occupies t+1..t+128/`UNROLL`.
  - `rdi_valid`=1 from t+1+128/`UNROLL`.
- Request at t, buffer full (prefetch):
  - `rdi_valid`=0 at t+1 and 1 at t+2, with the new data.
  - Refill starts at t+2.
- `rdi_valid` is never 1 in the cycle immediately after `rdi_ready`.

## Configuration
- `TRIVIUM_PREFETCH_EN` defined:
  - After each serve, and after warm-up, GEN runs ahead and fills a separate 128-bit prefetch buffer. Service latency is 2 cycles when the buffer is full.
- Not defined:
  - The block generates only on request; no second buffer exists.
  - Latency is always 1+128/`UNROLL`.
  - The keystream sequence is identical with or without the macro.

## Structure
- Package `prng_pkg` holds:
  - `TRIV_STATE_W`=288, `TRIV_WARMUP`=1152, `RDI_WORD_W`=128.
  - The state enum {UNSEEDED, WARMUP, GEN, IDLE}.
- Sub-module `trivium_rounds`: combinational; takes the 288-bit state in and produces the next state plus `UNROLL` z bits out. It is instantiated once and feeds both WARMUP and GEN.

## Test plan
- **Reset:** `rst` for 2 cycles, then `rdi_ready` pulses with no reseed → `rdi_valid` stays 0, no `reseed_ack`, `pend`=1.
- **Known answer:** `seed`=0 and `reseed`, then 8 requests → `reseed_ack` exactly 37 cycles after `reseed` (`UNROLL`=32). The 1024 bits match the golden C Trivium model with key=0, IV=0.
- **Unroll sweep:** `UNROLL`=1 and 64 with the same seed → bit-identical words. Ack delays are 1153 and 19 cycles.
- **Stability:** request, then hold 200 cycles → `rdi_data` unchanged and `rdi_valid`=1 throughout.
- **Mid-operation reseed:**
  - `reseed` with seed B asserted mid-GEN and mid-WARMUP → `rdi_valid` drops.
  - The first word after the new ack equals the first word of a clean seed-B run.
  - A pending request is served without being re-issued.
- **Back-to-back requests:** requests every 3 cycles with `TRIVIUM_PREFETCH_EN` defined → stream equals the model; no word is skipped or repeated. Latency is 2 when prefetched and 5 otherwise.

Source files
------------

// File: rtl/trivium_prng_pkg.sv
// prng_pkg: shared constants, FSM state type and the key/IV load helper
// for the Trivium keystream generator (trivium_prng, trivium_rounds).
//   TRIV_STATE_W : width of the Trivium state (s1..s288)
//   TRIV_WARMUP  : number of discarded rounds after a key/IV load
//   RDI_WORD_W   : width of one word delivered to the sampler
package prng_pkg;

   localparam int TRIV_STATE_W = 288;
   localparam int TRIV_WARMUP  = 1152;
   localparam int RDI_WORD_W   = 128;
   localparam int SEED_W       = 256;
   localparam int CNT_W        = 11;

   typedef enum logic [1:0] {
      UNSEEDED = 2'd0,
      WARMUP   = 2'd1,
      GEN      = 2'd2,
      IDLE     = 2'd3
   } prng_state_e;

   // Initial Trivium state: key in s1..s80, IV in s94..s173, s286..s288 set.
   function automatic logic [TRIV_STATE_W-1:0] triv_load(input logic [159:0] key_iv);
      logic [TRIV_STATE_W-1:0] st;
      st          = '0;
      st[79:0]    = key_iv[79:0];
      st[172:93]  = key_iv[159:80];
      st[287:285] = 3'b111;
      return st;
   endfunction

endpackage

// File: rtl/trivium_prng_rounds.sv
// trivium_rounds: combinational block applying UNROLL Trivium rounds.
// Ports:
//   st_in  [287:0]      current state, st_in[k-1] = s_k
//   st_out [287:0]      state after UNROLL rounds
//   z      [UNROLL-1:0] keystream bits, z[0] produced by the first round
module trivium_rounds
   import prng_pkg::*;
#(
   parameter int UNROLL = 32
) (
   input  logic [TRIV_STATE_W-1:0] st_in,
   output logic [TRIV_STATE_W-1:0] st_out,
   output logic [UNROLL-1:0]       z
);

   logic [TRIV_STATE_W-1:0] s_s;
   logic [UNROLL-1:0]       z_s;
   logic                    t1_s;
   logic                    t2_s;
   logic                    t3_s;

   // Unrolled round chain; each iteration shifts registers A, B and C by one.
   always_comb begin
      s_s  = st_in;
      z_s  = '0;
      t1_s = 1'b0;
      t2_s = 1'b0;
      t3_s = 1'b0;
      for (int i = 0; i < UNROLL; i++) begin
         t1_s   = s_s[65]  ^ s_s[92];
         t2_s   = s_s[161] ^ s_s[176];
         t3_s   = s_s[242] ^ s_s[287];
         z_s[i] = t1_s ^ t2_s ^ t3_s;
         t1_s   = t1_s ^ (s_s[90]  & s_s[91])  ^ s_s[170];
         t2_s   = t2_s ^ (s_s[174] & s_s[175]) ^ s_s[263];
         t3_s   = t3_s ^ (s_s[285] & s_s[286]) ^ s_s[68];
         // C: s178..s288 takes t2; B: s94..s177 takes t1; A: s1..s93 takes t3
         s_s    = {s_s[286:177], t2_s, s_s[175:93], t1_s, s_s[91:0], t3_s};
      end
   end

   assign st_out = s_s;
   assign z      = z_s;

endmodule

// File: rtl/trivium_prng.sv
// trivium_prng: Trivium keystream generator serving 128-bit words to the
// binomial sampler over the rdi_data/rdi_valid/rdi_ready link.
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   seed [255:0]       key = seed[79:0], IV = seed[159:80]; upper bits unused
//   reseed             pulse: load key/IV and restart warm-up
//   reseed_ack         pulse: warm-up finished
//   rdi_data [127:0]   served word, first keystream bit in bit 0
//   rdi_valid          rdi_data holds a fresh, unconsumed word
//   rdi_ready          request pulse for the next word
// Build option: TRIVIUM_PREFETCH_EN makes the generator fill one word ahead
// after warm-up and after each serve; otherwise words are generated on demand.
module trivium_prng
   import prng_pkg::*;
#(
   parameter int UNROLL = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [SEED_W-1:0]     seed,
   input  logic                  reseed,
   output logic                  reseed_ack,
   output logic [RDI_WORD_W-1:0] rdi_data,
   output logic                  rdi_valid,
   input  logic                  rdi_ready
);

   localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(TRIV_WARMUP / UNROLL - 1);
   localparam logic [CNT_W-1:0] GEN_LAST  = CNT_W'(RDI_WORD_W / UNROLL - 1);
`ifdef TRIVIUM_PREFETCH_EN
   localparam logic PREFETCH = 1'b1;
`else
   localparam logic PREFETCH = 1'b0;
`endif

   prng_state_e             state_r, state_s;
   logic [TRIV_STATE_W-1:0] st_r, st_s, st_nx_s;
   logic [CNT_W-1:0]        cnt_r, cnt_s;
   logic [RDI_WORD_W-1:0]   buf_r, buf_s, word_s;
   logic                    buf_full_r, buf_full_s;
   logic                    pend_r, pend_s;
   logic [RDI_WORD_W-1:0]   data_r, data_s;
   logic                    valid_r, valid_s;
   logic                    ack_r, ack_s;
   logic [UNROLL-1:0]       z_s;
   logic                    unused_seed_s;

   assign unused_seed_s = ^seed[SEED_W-1:160];

   trivium_rounds #(.UNROLL(UNROLL)) u_rounds (
      .st_in  (st_r),
      .st_out (st_nx_s),
      .z      (z_s)
   );

   // Buffer contents after this cycle's keystream bits shift in from the top.
   assign word_s = {z_s, buf_r[RDI_WORD_W-1:UNROLL]};

   // Next-state logic: reseed dominates; serving is deferred while rdi_ready
   // is high so that valid never rises in the cycle after a request.
   always_comb begin
      state_s    = state_r;
      st_s       = st_r;
      cnt_s      = cnt_r;
      buf_s      = buf_r;
      buf_full_s = buf_full_r;
      pend_s     = pend_r | rdi_ready;
      data_s     = data_r;
      valid_s    = valid_r & ~rdi_ready;
      ack_s      = 1'b0;
      if (reseed) begin
         st_s       = triv_load(seed[159:0]);
         state_s    = WARMUP;
         cnt_s      = '0;
         buf_s      = '0;
         buf_full_s = 1'b0;
         valid_s    = 1'b0;
      end else begin
         case (state_r)
            UNSEEDED: begin
               state_s = UNSEEDED;
            end
            WARMUP: begin
               st_s = st_nx_s;
               if (cnt_r == WARM_LAST) begin
                  ack_s = 1'b1;
                  cnt_s = '0;
                  if (PREFETCH || pend_s) begin
                     state_s = GEN;
                  end else begin
                     state_s = IDLE;
                  end
               end else begin
                  cnt_s = cnt_r + 11'd1;
               end
            end
            GEN: begin
               st_s  = st_nx_s;
               buf_s = word_s;
               if (cnt_r == GEN_LAST) begin
                  cnt_s = '0;
                  if (pend_r && !rdi_ready) begin
                     data_s     = word_s;
                     valid_s    = 1'b1;
                     pend_s     = 1'b0;
                     buf_full_s = 1'b0;
                     if (PREFETCH) begin
                        state_s = GEN;
                     end else begin
                        state_s = IDLE;
                     end
                  end else begin
                     buf_full_s = 1'b1;
                     state_s    = IDLE;
                  end
               end else begin
                  cnt_s = cnt_r + 11'd1;
               end
            end
            IDLE: begin
               if (pend_r && !rdi_ready && buf_full_r) begin
                  data_s     = buf_r;
                  valid_s    = 1'b1;
                  pend_s     = 1'b0;
                  buf_full_s = 1'b0;
                  cnt_s      = '0;
                  if (PREFETCH) begin
                     state_s = GEN;
                  end else begin
                     state_s = IDLE;
                  end
               end else if (pend_s && !buf_full_r) begin
                  state_s = GEN;
                  cnt_s   = '0;
               end else begin
                  state_s = IDLE;
               end
            end
            default: begin
               state_s = UNSEEDED;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= UNSEEDED;
         st_r       <= '0;
         cnt_r      <= '0;
         buf_r      <= '0;
         buf_full_r <= 1'b0;
         pend_r     <= 1'b0;
         data_r     <= '0;
         valid_r    <= 1'b0;
         ack_r      <= 1'b0;
      end else begin
         state_r    <= state_s;
         st_r       <= st_s;
         cnt_r      <= cnt_s;
         buf_r      <= buf_s;
         buf_full_r <= buf_full_s;
         pend_r     <= pend_s;
         data_r     <= data_s;
         valid_r    <= valid_s;
         ack_r      <= ack_s;
      end
   end

   assign reseed_ack = ack_r;
   assign rdi_data   = data_r;
   assign rdi_valid  = valid_r;

endmodule

// File: tb/tb_trivium_prng.sv
// Self-checking bench for trivium_prng. Expected words come from a bit-level
// Trivium model (s1..s288 as an array); a monitor pops and compares each word
// when rdi_valid rises. Works for both builds: the prefetch mode is inferred
// from the latency of a request made long after the last serve.
module tb_trivium_prng;

   localparam int GEN = 4;   // 128 / UNROLL for the main DUT (UNROLL = 32)

   logic         clk;
   logic         rst;
   logic [255:0] seed;
   logic         reseed;
   logic         reseed_ack;
   logic [127:0] rdi_data;
   logic         rdi_valid;
   logic         rdi_ready;

   logic [255:0] seed_b;
   logic         reseed_b;
   logic         ready_b;
   logic         ack_1, ack_64, valid_1, valid_64;
   logic [127:0] data_1, data_64;

   trivium_prng #(.UNROLL(32)) dut (
      .clk(clk), .rst(rst), .seed(seed), .reseed(reseed), .reseed_ack(reseed_ack),
      .rdi_data(rdi_data), .rdi_valid(rdi_valid), .rdi_ready(rdi_ready)
   );

   trivium_prng #(.UNROLL(1)) dut_u1 (
      .clk(clk), .rst(rst), .seed(seed_b), .reseed(reseed_b), .reseed_ack(ack_1),
      .rdi_data(data_1), .rdi_valid(valid_1), .rdi_ready(ready_b)
   );

   trivium_prng #(.UNROLL(64)) dut_u64 (
      .clk(clk), .rst(rst), .seed(seed_b), .reseed(reseed_b), .reseed_ack(ack_64),
      .rdi_data(data_64), .rdi_valid(valid_64), .rdi_ready(ready_b)
   );

   int           n_vec = 0;
   int           n_err = 0;
   int           cyc = 0;
   logic [127:0] exp_q[$];
   bit           outstanding = 1'b0;
   bit           seeded = 1'b0;
   bit           prefetch_mode = 1'b0;
   int           req_cyc = 0;
   int           serve_cyc = 0;
   int           last_lat = 0;

   // Reference model state: ms[k] is Trivium s_k.
   bit ms [1:288];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_round(output bit z);
      bit t1, t2, t3;
      t1 = ms[66]  ^ ms[93];
      t2 = ms[162] ^ ms[177];
      t3 = ms[243] ^ ms[288];
      z  = t1 ^ t2 ^ t3;
      t1 = t1 ^ (ms[91]  & ms[92])  ^ ms[171];
      t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
      t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
      for (int k = 288; k > 1; k--) ms[k] = ms[k-1];
      ms[1]   = t3;
      ms[94]  = t1;
      ms[178] = t2;
   endtask

   task automatic model_load(input logic [255:0] sd);
      bit z;
      for (int k = 1; k <= 288; k++) ms[k] = 1'b0;
      for (int i = 0; i < 80; i++) begin
         ms[1 + i]  = sd[i];
         ms[94 + i] = sd[80 + i];
      end
      ms[286] = 1'b1;
      ms[287] = 1'b1;
      ms[288] = 1'b1;
      for (int i = 0; i < 1152; i++) model_round(z);
   endtask

   task automatic model_word(output logic [127:0] w);
      bit z;
      for (int i = 0; i < 128; i++) begin
         model_round(z);
         w[i] = z;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic request();
      logic [127:0] w;
      rdi_ready = 1'b1;
      if (!outstanding) begin
         if (seeded) begin
            model_word(w);
            exp_q.push_back(w);
         end
         outstanding = 1'b1;
         req_cyc = cyc;
      end
      tick();
      rdi_ready = 1'b0;
   endtask

   // Reseed (optionally with a simultaneous request); a pending request is
   // expected to be answered with the first word of the new seed.
   task automatic do_reseed(input logic [255:0] sd, input bit with_req);
      logic [127:0] w;
      seed   = sd;
      reseed = 1'b1;
      if (with_req) begin
         rdi_ready = 1'b1;
         if (!outstanding) req_cyc = cyc;
         outstanding = 1'b1;
      end
      model_load(sd);
      seeded = 1'b1;
      if (outstanding) begin
         exp_q.delete();
         model_word(w);
         exp_q.push_back(w);
      end
      tick();
      reseed    = 1'b0;
      rdi_ready = 1'b0;
   endtask

   // Called one cycle after the reseed cycle.
   task automatic check_ack(input int exp_d);
      int n;
      n = 1;
      while (!reseed_ack && n < 1300) begin
         tick();
         n++;
      end
      check("ack_delay", 128'(n), 128'(exp_d));
      tick();
      check("ack_single_pulse", {127'd0, reseed_ack}, 128'd0);
   endtask

   task automatic wait_served(input int bound);
      for (int n = 0; n < bound; n++) begin
         if (!outstanding) break;
         tick();
      end
      check("serve_timeout", {127'd0, outstanding}, 128'd0);
   endtask

   function automatic int exp_lat(input int r);
      int l;
      if (prefetch_mode) begin
         l = serve_cyc + GEN - r;
         return (l < 2) ? 2 : l;
      end else begin
         return 1 + GEN;
      end
   endfunction

   task automatic req_and_check(input string name);
      int el;
      el = exp_lat(cyc);
      request();
      wait_served(60);
      check(name, 128'(last_lat), 128'(el));
   endtask

   // Monitor: compare each newly presented word, check stability and the
   // no-valid-after-request rule.
   initial begin
      logic         v_q;
      logic         r_q;
      logic [127:0] d_q;
      logic [127:0] w;
      v_q = 1'b0;
      r_q = 1'b0;
      d_q = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            v_q = 1'b0;
            r_q = 1'b0;
         end else begin
            if (r_q) check("valid_after_ready", {127'd0, rdi_valid}, 128'd0);
            if (rdi_valid && !v_q) begin
               check("serve_expected", 128'(exp_q.size()), 128'd1);
               if (exp_q.size() > 0) begin
                  w = exp_q.pop_front();
                  check("word", rdi_data, w);
               end
               outstanding = 1'b0;
               last_lat    = cyc - req_cyc;
               serve_cyc   = cyc;
            end else if (rdi_valid && v_q) begin
               check("data_stable", rdi_data, d_q);
            end
            v_q = rdi_valid;
            d_q = rdi_data;
            r_q = rdi_ready;
         end
      end
   end

   initial begin
      logic [255:0] seed_a, seed_bb;
      logic [127:0] saved, w0;
      int           bad, lat, d1, d64, nxt;
      rst = 1'b1; seed = '0; reseed = 1'b0; rdi_ready = 1'b0;
      seed_b = '0; reseed_b = 1'b0; ready_b = 1'b0;
      for (int i = 0; i < 8; i++) begin
         seed_a[i*32 +: 32]  = $urandom();
         seed_bb[i*32 +: 32] = $urandom();
      end

      // Reset values
      tick(); tick();
      check("rst_valid", {127'd0, rdi_valid}, 128'd0);
      check("rst_ack", {127'd0, reseed_ack}, 128'd0);
      check("rst_data", rdi_data, 128'd0);
      rst = 1'b0;
      tick();

      // Requests before any seed: nothing served, no ack, request stays pending
      request();
      tick();
      request();
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (reseed_ack || rdi_valid) bad++;
         tick();
      end
      check("unseeded_quiet", 128'(bad), 128'd0);

      // Key = 0, IV = 0: pending request served with the first word
      do_reseed(256'd0, 1'b0);
      check_ack(37);
      wait_served(60);

      // Long-idle request: latency 2 with prefetch, 1+128/UNROLL without
      repeat (20) tick();
      request();
      wait_served(60);
      lat = last_lat;
      check("mode_latency", {127'd0, (lat == 2) || (lat == 1 + GEN)}, 128'd1);
      prefetch_mode = (lat == 2);

      // Hold for 200 cycles: word and valid unchanged
      saved = rdi_data;
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         if (!rdi_valid || rdi_data !== saved) bad++;
         tick();
      end
      check("hold_200", 128'(bad), 128'd0);

      // Remaining known-answer words with random gaps
      for (int i = 0; i < 6; i++) begin
         nxt = serve_cyc + $urandom_range(1, 8);
         while (cyc < nxt) tick();
         req_and_check("kat_latency");
      end

      // Random seed, random gaps, then requests every 3 cycles
      do_reseed(seed_a, 1'b0);
      check_ack(37);
      for (int i = 0; i < 10; i++) begin
         nxt = serve_cyc + $urandom_range(1, 8);
         while (cyc < nxt) tick();
         req_and_check("rand_latency");
      end
      for (int i = 0; i < 6; i++) begin
         nxt = req_cyc + 3;
         if (nxt < serve_cyc + 1) nxt = serve_cyc + 1;
         while (cyc < nxt) tick();
         req_and_check("b2b_latency");
      end

      // Mid-warm-up reseed: valid drops; reseed plus request in one cycle
      check("valid_before_reseed", {127'd0, rdi_valid}, 128'd1);
      do_reseed(seed_bb, 1'b0);
      check("valid_drop_reseed", {127'd0, rdi_valid}, 128'd0);
      repeat (10) tick();
      do_reseed(seed_bb, 1'b1);
      check_ack(37);
      wait_served(60);

      // Mid-generation reseed with a pending request that is not re-issued
      do_reseed(seed_a, 1'b0);
      check("valid_drop_reseed2", {127'd0, rdi_valid}, 128'd0);
      check_ack(37);
      tick();
      request();
      do_reseed(seed_bb, 1'b0);
      check_ack(37);
      wait_served(60);

      // Unroll sweep: UNROLL = 1 and 64, key = 0, IV = 0
      model_load(256'd0);
      model_word(w0);
      seed_b   = 256'd0;
      reseed_b = 1'b1;
      tick();
      reseed_b = 1'b0;
      d1  = 0;
      d64 = 0;
      for (int n = 1; n <= 1300; n++) begin
         if (ack_1 && d1 == 0) d1 = n;
         if (ack_64 && d64 == 0) d64 = n;
         if (d1 != 0 && d64 != 0) break;
         tick();
      end
      check("ack_delay_u1", 128'(d1), 128'd1153);
      check("ack_delay_u64", 128'(d64), 128'd19);
      repeat (3) tick();
      ready_b = 1'b1;
      tick();
      ready_b = 1'b0;
      for (int n = 0; n < 300; n++) begin
         if (valid_1 && valid_64) break;
         tick();
      end
      check("valid_u1", {127'd0, valid_1}, 128'd1);
      check("valid_u64", {127'd0, valid_64}, 128'd1);
      check("word_u1", data_1, w0);
      check("word_u64", data_64, w0);

      check("queue_drained", 128'(exp_q.size()), 128'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
